// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the 7-segment scan driver:
//   - glyph patterns for hex digits 0..F (segments a..g, a in the MSB)
//   - bit positions of each segment in the 8-bit segment bus
//   - scan FSM state encoding
package seg7_pkg;

    // Segment positions on the 8-bit bus: a is bit 7 down to g at bit 1, dp at bit 0.
    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    // Glyphs, ordered a..g from MSB to LSB.
    localparam logic [6:0] GLYPH_0 = 7'b1111110;
    localparam logic [6:0] GLYPH_1 = 7'b0110000;
    localparam logic [6:0] GLYPH_2 = 7'b1101101;
    localparam logic [6:0] GLYPH_3 = 7'b1111001;
    localparam logic [6:0] GLYPH_4 = 7'b0110011;
    localparam logic [6:0] GLYPH_5 = 7'b1011011;
    localparam logic [6:0] GLYPH_6 = 7'b1011111;
    localparam logic [6:0] GLYPH_7 = 7'b1110000;
    localparam logic [6:0] GLYPH_8 = 7'b1111111;
    localparam logic [6:0] GLYPH_9 = 7'b1111011;
    localparam logic [6:0] GLYPH_A = 7'b1110111;
    localparam logic [6:0] GLYPH_B = 7'b0011111;
    localparam logic [6:0] GLYPH_C = 7'b0001101;
    localparam logic [6:0] GLYPH_D = 7'b0111101;
    localparam logic [6:0] GLYPH_E = 7'b1001111;
    localparam logic [6:0] GLYPH_F = 7'b1000111;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if
// Register-file side inputs and board-pin side outputs of the scan driver.
//   enable       scan enable
//   value        NUM_DIGITS hex nibbles, digit 0 in bits [3:0]
//   dp           decimal point per digit
//   blank        force digit fully dark (including dp)
//   lz_suppress  leading-zero suppression enable
//   seg_out      segment pins {a,b,c,d,e,f,g,dp}
//   dig_out      digit select pins
//   frame_start  one-cycle pulse when a new snapshot is taken
// master: the register file / stimulus side; slave: the driver.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 8
) ();
    logic                      enable;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     dp;
    logic [NUM_DIGITS-1:0]     blank;
    logic                      lz_suppress;
    logic [7:0]                seg_out;
    logic [NUM_DIGITS-1:0]     dig_out;
    logic                      frame_start;

    modport master (
        output enable, value, dp, blank, lz_suppress,
        input  seg_out, dig_out, frame_start
    );

    modport slave (
        input  enable, value, dp, blank, lz_suppress,
        output seg_out, dig_out, frame_start
    );
endinterface

// File: rtl/seg7_scan_driver_hex_glyph.sv
// hex_glyph
// Combinational hex nibble to 7-segment pattern lookup.
//   nib  in   4  hex value
//   seg  out  7  segments a..g (a in bit 6), 1 = lit
module hex_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    always_comb begin
        seg = '0;
        case (nib)
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = GLYPH_A;
            4'hB: seg = GLYPH_B;
            4'hC: seg = GLYPH_C;
            4'hD: seg = GLYPH_D;
            4'hE: seg = GLYPH_E;
            4'hF: seg = GLYPH_F;
            default: seg = '0;
        endcase
    end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for NUM_DIGITS 7-segment digits on a shared
// segment bus. Inputs are snapshotted once per frame; digits are then
// scanned round-robin, PRESCALE cycles per digit, with the first
// DEAD_CYCLES of each slot dark to avoid ghosting.
//   clock   in   system clock
//   reset   in   asynchronous active-low reset (release expected synchronous to clock)
//   bus     slave modport of seg7_scan_driver_if (inputs, pins, frame_start)
// Outputs are registered: pins at cycle t+1 reflect state/cnt/idx at cycle t.
// The interface instance must be built with the same NUM_DIGITS.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int PRESCALE       = 1000,
    parameter int DEAD_CYCLES    = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    seg7_scan_driver_if.slave    bus
);
    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        cnt, cnt_nx;
    logic [IDX_W-1:0]        idx, idx_nx;
    logic                    snap_take;
    logic                    frame_start_q;

    logic [4*NUM_DIGITS-1:0] snap_value;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [NUM_DIGITS-1:0]   snap_blank;
    logic                    snap_lz;

    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    zero_above;
    logic [3:0]              cur_nib;
    logic [6:0]              glyph;
    logic                    dark;
    logic [7:0]              seg_d, seg_q;
    logic [NUM_DIGITS-1:0]   dig_d, dig_q;

    // Next-state: counters are zero in IDLE and whenever scan starts; a
    // snapshot is taken on entry to SCAN and on every frame wrap.
    always_comb begin
        state_nx  = state;
        cnt_nx    = '0;
        idx_nx    = '0;
        snap_take = 1'b0;
        case (state)
            IDLE: begin
                if (bus.enable) begin
                    state_nx  = SCAN;
                    snap_take = 1'b1;
                end
            end
            SCAN: begin
                if (!bus.enable) begin
                    state_nx = IDLE;
                end else if (cnt == CNT_LAST) begin
                    if (idx == IDX_LAST) begin
                        snap_take = 1'b1;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                    idx_nx = idx;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            frame_start_q <= 1'b0;
            snap_value    <= '0;
            snap_dp       <= '0;
            snap_blank    <= '0;
            snap_lz       <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            idx           <= idx_nx;
            frame_start_q <= snap_take;
            if (snap_take) begin
                snap_value <= bus.value;
                snap_dp    <= bus.dp;
                snap_blank <= bus.blank;
                snap_lz    <= bus.lz_suppress;
            end
        end
    end

    // Digit i (i>=1) is a leading zero when it and every digit above it
    // are zero. Digit 0 always shows, so an all-zero value reads "0".
    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (snap_value[4*i +: 4] == 4'h0);
            lz_mask[i] = snap_lz & zero_above;
        end
    end

    assign cur_nib = snap_value[{idx, 2'b00} +: 4];

    hex_glyph u_glyph (
        .nib (cur_nib),
        .seg (glyph)
    );

    assign dark = (state != SCAN) || (32'(cnt) < DEAD_CYCLES) || snap_blank[idx];

    // Suppressed digits keep their dp and their digit select; only a..g go dark.
    always_comb begin
        seg_d = '0;
        dig_d = '0;
        if (!dark) begin
            dig_d               = NUM_DIGITS'(1) << idx;
            seg_d[SEG_A:SEG_G]  = lz_mask[idx] ? 7'b0 : glyph;
            seg_d[SEG_DP]       = snap_dp[idx];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg_q <= '0;
            dig_q <= '0;
        end else begin
            seg_q <= seg_d;
            dig_q <= dig_d;
        end
    end

    assign bus.seg_out     = seg_q ^ {8{SEG_ACTIVE_LOW}};
    assign bus.dig_out     = dig_q ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
// Directed bench: NUM_DIGITS=4, PRESCALE=8, DEAD_CYCLES=2, active-low digits.
// Expected pin values per cycle are queued when stimulus is set up and
// popped/compared at each falling edge.
module tb_seg7_scan_driver;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.NUM_DIGITS(4)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS     (4),
        .PRESCALE       (8),
        .DEAD_CYCLES    (2),
        .SEG_ACTIVE_LOW (1'b0),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [3:0] dig;
        logic [7:0] seg;
        logic       fs;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Sample right after the enabling edge, or any idle cycle.
    task automatic push_idle(input logic fs);
        exp_t e;
        e.dig = 4'hF;
        e.seg = 8'h00;
        e.fs  = fs;
        q.push_back(e);
    endtask

    // Samples j=jlo..jhi of a frame; sample j shows slot position j-1,
    // and sample 32 coincides with the next frame_start.
    task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3,
                              input logic [3:0] blk, input int jlo, input int jhi);
        logic [7:0] segs [4];
        exp_t e;
        int   c, d, cn;
        bit   act;
        segs = '{s0, s1, s2, s3};
        for (int j = jlo; j <= jhi; j++) begin
            c   = j - 1;
            d   = c / 8;
            cn  = c % 8;
            act = (cn >= 2) && !blk[d];
            e.fs  = (j == 32);
            e.dig = act ? ~(4'b0001 << d) : 4'hF;
            e.seg = act ? segs[d] : 8'h00;
            q.push_back(e);
        end
    endtask

    task automatic run(input int n, input string tag);
        exp_t e;
        repeat (n) begin
            @(negedge clk);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL %s expected-queue empty", tag);
            end else begin
                e = q.pop_front();
                chk({tag, ".fs"},  16'(bus.frame_start), 16'(e.fs));
                chk({tag, ".dig"}, 16'(bus.dig_out),     16'(e.dig));
                chk({tag, ".seg"}, 16'(bus.seg_out),     16'(e.seg));
            end
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.enable      = 1'b1;
        bus.value       = 16'h12A5;
        bus.dp          = 4'b0000;
        bus.blank       = 4'b0000;
        bus.lz_suppress = 1'b0;

        // Held in reset with enable high: pins inactive, no pulse.
        repeat (3) @(negedge clk);
        chk("rst.seg", 16'(bus.seg_out), 16'h0000);
        chk("rst.dig", 16'(bus.dig_out), 16'h000F);
        chk("rst.fs",  16'(bus.frame_start), 16'h0000);
        rst_n = 1'b1;

        push_idle(1'b1);
        run(1, "start");

        // Frame 0: 12A5. Value changes mid-frame (digit-1 slot) must not show yet.
        push_frame(8'hB6, 8'hEE, 8'hDA, 8'h60, 4'b0000, 1, 32);
        run(16, "f0");
        bus.value = 16'hFFFF;
        run(16, "f0");

        // Frame 1: all F.
        push_frame(8'h8E, 8'h8E, 8'h8E, 8'h8E, 4'b0000, 1, 32);
        run(16, "f1");
        bus.lz_suppress = 1'b1;
        bus.value       = 16'h0070;
        bus.dp          = 4'b1000;
        run(16, "f1");

        // Frame 2: leading-zero suppression of 0070 with dp on digit 3.
        push_frame(8'hFC, 8'hE0, 8'h00, 8'h01, 4'b0000, 1, 32);
        run(16, "f2");
        bus.value = 16'h0000;
        bus.dp    = 4'b0000;
        run(16, "f2");

        // Frame 3: all-zero value keeps digit 0.
        push_frame(8'hFC, 8'h00, 8'h00, 8'h00, 4'b0000, 1, 32);
        run(16, "f3");
        bus.lz_suppress = 1'b0;
        bus.value       = 16'h12A5;
        bus.blank       = 4'b0010;
        bus.dp          = 4'b0010;
        run(16, "f3");

        // Frame 4: digit 1 blanked, dp included.
        push_frame(8'hB6, 8'hEF, 8'hDA, 8'h60, 4'b0010, 1, 32);
        run(16, "f4");
        bus.blank = 4'b0000;
        bus.dp    = 4'b0000;
        run(16, "f4");

        // Frame 5: enable dropped mid digit-1 slot; one more active cycle, then dark.
        push_frame(8'hB6, 8'hEE, 8'hDA, 8'h60, 4'b0000, 1, 13);
        run(12, "f5");
        bus.enable = 1'b0;
        push_idle(1'b0);
        push_idle(1'b0);
        push_idle(1'b0);
        run(4, "drop");

        // Re-enable restarts at digit 0 with a fresh frame_start.
        bus.enable = 1'b1;
        push_idle(1'b1);
        run(1, "reen");
        push_frame(8'hB6, 8'hEE, 8'hDA, 8'h60, 4'b0000, 1, 20);
        run(20, "reen");

        // Async reset mid digit-2 slot: pins go dark without waiting for a clock.
        rst_n = 1'b0;
        #1;
        chk("arst.seg", 16'(bus.seg_out), 16'h0000);
        chk("arst.dig", 16'(bus.dig_out), 16'h000F);
        chk("arst.fs",  16'(bus.frame_start), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        push_idle(1'b1);
        run(1, "rst2");
        push_frame(8'hB6, 8'hEE, 8'hDA, 8'h60, 4'b0000, 1, 32);
        run(32, "rst2");

        chk("drain", 16'(q.size()), 16'h0000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for a bank of NUM_DIGITS common-anode/cathode 7-segment digits sharing one segment bus.
- Snapshots per-digit hex values, decimal points and blank masks once per frame, then scans the digits round-robin with a programmable slot length and anti-ghosting dead time.
- Optional leading-zero suppression. Sits between the CPU/debug register file and the board display pins.

Parameters:
- NUM_DIGITS, 8: digits driven; legal 1..16.
- PRESCALE, 1000: clock cycles per digit slot; must be at least DEAD_CYCLES+1.
- DEAD_CYCLES, 16: cycles at the start of each slot with all digits off; 0 disables dead time.
- SEG_ACTIVE_LOW, 0: 1 inverts seg_out at the pins.
- DIG_ACTIVE_LOW, 1: 1 inverts dig_out at the pins.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  scan enable.
- value  in  4*NUM_DIGITS  hex nibbles; digit i is value[4i+3:4i], digit 0 is least significant.
- dp  in  NUM_DIGITS  decimal point per digit.
- blank  in  NUM_DIGITS  force digit fully dark, including dp.
- lz_suppress  in  1  leading-zero suppression enable.
- seg_out  out  8  segments, bit7=a … bit1=g, bit0=dp; logical 1 = lit before SEG_ACTIVE_LOW.
- dig_out  out  NUM_DIGITS  digit select, one-hot when active; logical 1 = on before DIG_ACTIVE_LOW.
- frame_start  out  1  one-cycle pulse when a new snapshot is taken.

Behaviour:
- Reset (async assert, sync release):
  - cnt=0, idx=0, state=IDLE.
  - Snapshot registers cleared.
  - seg_out and dig_out at inactive pin levels, i.e. all logical 0.
  - frame_start=0.
- State IDLE:
  - Counters held at 0; outputs inactive.
  - enable=1 → SCAN. On that same edge: snapshot value/dp/blank/lz_suppress, pulse frame_start, idx=0, cnt=0.
- State SCAN:
  - cnt counts 0..PRESCALE-1.
  - At cnt=PRESCALE-1: cnt→0 and idx→idx+1.
  - At the wrap from idx=NUM_DIGITS-1 to 0: take a new snapshot and pulse frame_start on the same edge.
- enable=0 in SCAN → IDLE on the next edge. The current slot is abandoned and outputs go inactive one cycle later. Re-enable restarts at digit 0 with a fresh snapshot.
- Output registers (one-cycle latency: outputs at cycle t+1 reflect state, cnt and idx at cycle t):
  - If state=IDLE, or cnt<DEAD_CYCLES, or snap_blank[idx]: all digits off and seg=0.
  - Otherwise: dig bit idx on, all other digits off; seg = glyph(snap_value[idx]) with seg[0]=snap_dp[idx].
- Glyph patterns (a..g, bit7..bit1):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, c=0001101, d=0111101, E=1001111, F=1000111
- Leading-zero suppression (when snap_lz=1):
  - Digit i (i≥1) has a..g forced off if snap_value[j]==0 for all j≥i. Digit 0 is never suppressed.
  - dp of a suppressed digit is still shown. The digit select stays active unless that digit is blanked.
- Inputs are only sampled at snapshot edges. Changes mid-frame take effect at the next frame_start.
- NUM_DIGITS=1: idx is constant 0 and every slot end is a frame wrap.
- Polarity inversion is applied to the registered outputs with no extra latency.

Decomposition:
- Package seg7_pkg:
  - the 16 glyph constants;
  - segment bit-index constants (SEG_A..SEG_G, SEG_DP);
  - state encoding IDLE/SCAN.
- Sub-module hex_glyph: combinational 4-bit→7-bit glyph lookup, instantiated once on the muxed nibble.
- Leading-zero mask: combinational logic in the top module, computed from the snapshot.

Test Plan (NUM_DIGITS=4, PRESCALE=8, DEAD_CYCLES=2, SEG_ACTIVE_LOW=0, DIG_ACTIVE_LOW=1):
- Reset held, enable=1 → seg_out=8'h00, dig_out=4'b1111, frame_start=0; after release, frame_start pulses exactly once.
- value=16'h12A5, dp=0, blank=0:
  - Per slot: 2 cycles with dig_out=4'b1111, then 6 cycles active.
  - Scan order and patterns: dig_out=1110 seg=8'hB6, 1101 seg=8'hEE, 1011 seg=8'hDA, 0111 seg=8'h60.
  - frame_start every 32 cycles.
- value changed to 16'hFFFF during digit-1 slot → digits 2 and 3 still show 8'hDA/8'h60; all digits show 8'h8E from the next frame_start.
- lz_suppress=1, value=16'h0070, dp=4'b1000 → digit3 seg=8'h01, digit2 seg=8'h00, digit1 seg=8'hE0, digit0 seg=8'hFC. With value=0: digits 1–3 seg=8'h00, digit0 seg=8'hFC.
- blank=4'b0010, dp=4'b0010 → during the digit-1 slot, dig_out=4'b1111 and seg=8'h00; other digits unaffected.
- enable dropped mid-slot → outputs inactive next cycle. Async reset asserted mid-scan → outputs inactive immediately; after release, scan restarts at digit 0 with a new frame_start.
